// File: rtl/canvas_writer.sv
// Pen-stamp and full-screen-clear writer for port A of the 320x240 RGB444 frame buffer.
// Every output is registered; mem_addr/mem_din hold their last value whenever mem_we is low.
module canvas_writer #(
  parameter int unsigned WIDTH    = 320,
  parameter int unsigned HEIGHT   = 240,
  parameter int unsigned BRUSH    = 3,
  parameter logic [11:0] BG_COLOR = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pen_valid,
  output logic        pen_ready,
  input  logic [8:0]  pen_x,
  input  logic [7:0]  pen_y,
  input  logic [11:0] pen_color,
  input  logic        clear_req,
  output logic        busy,
  output logic        mem_we,
  output logic [16:0] mem_addr,
  output logic [11:0] mem_din
);

  localparam logic [2:0]  HALF  = 3'(BRUSH / 2);
  localparam logic [2:0]  BLAST = 3'(BRUSH - 1);
  localparam logic [5:0]  NPOS  = 6'(BRUSH * BRUSH);
  localparam logic [10:0] W11   = 11'(WIDTH);
  localparam logic [10:0] H11   = 11'(HEIGHT);
  localparam logic [16:0] W17   = 17'(WIDTH);
  localparam logic [16:0] CLR_N = 17'(WIDTH * HEIGHT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STAMP,
    S_CLEAR
  } state_t;

  state_t      r_state;
  logic        r_clear_pending;
  logic [8:0]  r_x;
  logic [7:0]  r_y;
  logic [11:0] r_color;
  logic [2:0]  r_dx;
  logic [2:0]  r_dy;
  logic [5:0]  r_cnt;
  logic [16:0] r_caddr;

  logic        w_go_clear;
  logic        w_accept;
  logic        w_stamp_done;
  logic        w_clear_done;
  logic        w_start_clear;
  logic        w_emit_stamp;
  logic        w_clear_step;
  logic [8:0]  w_bx;
  logic [7:0]  w_by;
  logic [11:0] w_bc;
  logic [2:0]  w_ix;
  logic [2:0]  w_iy;
  logic [2:0]  w_nx;
  logic [2:0]  w_ny;
  logic [10:0] w_px;
  logic [10:0] w_py;
  logic        w_hit;
  logic [16:0] w_addr;

  // The first stamp position is emitted on the accepting edge straight from the
  // pen inputs, so the position datapath selects between live and latched values.
  always_comb begin
    w_go_clear    = clear_req || r_clear_pending;
    w_accept      = (r_state == S_IDLE) && !w_go_clear && pen_valid && pen_ready;
    w_stamp_done  = (r_cnt == NPOS);
    w_clear_done  = (r_caddr == CLR_N);
    w_start_clear = w_go_clear &&
                    ((r_state == S_IDLE) || ((r_state == S_STAMP) && w_stamp_done));
    w_emit_stamp  = w_accept || ((r_state == S_STAMP) && !w_stamp_done);
    w_clear_step  = (r_state == S_CLEAR) && !w_clear_done;

    w_bx = w_accept ? pen_x     : r_x;
    w_by = w_accept ? pen_y     : r_y;
    w_bc = w_accept ? pen_color : r_color;
    w_ix = w_accept ? '0        : r_dx;
    w_iy = w_accept ? '0        : r_dy;

    // 11-bit two's complement: bit 10 set means the offset went left of / above the canvas
    w_px   = {2'b00, w_bx} + {8'd0, w_ix} - {8'd0, HALF};
    w_py   = {3'b000, w_by} + {8'd0, w_iy} - {8'd0, HALF};
    w_hit  = !w_px[10] && (w_px < W11) && !w_py[10] && (w_py < H11);
    w_addr = ({9'd0, w_py[7:0]} * W17) + {8'd0, w_px[8:0]};

    if (w_ix == BLAST) begin
      w_nx = '0;
      w_ny = w_iy + 3'd1;
    end else begin
      w_nx = w_ix + 3'd1;
      w_ny = w_iy;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= S_IDLE;
      r_clear_pending <= 1'b0;
      r_x             <= '0;
      r_y             <= '0;
      r_color         <= '0;
      r_dx            <= '0;
      r_dy            <= '0;
      r_cnt           <= '0;
      r_caddr         <= '0;
      pen_ready       <= 1'b0;
      busy            <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_din         <= '0;
    end else begin
      if ((r_state == S_STAMP) && clear_req) begin
        r_clear_pending <= 1'b1;
      end

      if (w_start_clear) begin
        // Overrides the pending flag set above when the request lands on the last stamp cycle.
        r_state         <= S_CLEAR;
        r_clear_pending <= 1'b0;
        r_caddr         <= 17'd1;
        mem_we          <= 1'b1;
        mem_addr        <= '0;
        mem_din         <= BG_COLOR;
        busy            <= 1'b1;
        pen_ready       <= 1'b0;
      end else if (w_emit_stamp) begin
        if (w_accept) begin
          r_x     <= pen_x;
          r_y     <= pen_y;
          r_color <= pen_color;
          r_cnt   <= 6'd1;
        end else begin
          r_cnt <= r_cnt + 6'd1;
        end
        r_state   <= S_STAMP;
        r_dx      <= w_nx;
        r_dy      <= w_ny;
        mem_we    <= w_hit;
        if (w_hit) begin
          mem_addr <= w_addr;
          mem_din  <= w_bc;
        end
        busy      <= 1'b1;
        pen_ready <= 1'b0;
      end else if (w_clear_step) begin
        mem_we   <= 1'b1;
        mem_addr <= r_caddr;
        r_caddr  <= r_caddr + 17'd1;
      end else begin
        r_state   <= S_IDLE;
        mem_we    <= 1'b0;
        busy      <= 1'b0;
        pen_ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_canvas_writer.sv
// Directed bench for canvas_writer: reset, stamps with clipping, clear sweeps,
// clear queued behind a stamp, and asynchronous reset in the middle of a clear.
module tb_canvas_writer;

  logic        clk;
  logic        rst;
  logic        pen_valid;
  logic        pen_ready;
  logic [8:0]  pen_x;
  logic [7:0]  pen_y;
  logic [11:0] pen_color;
  logic        clear_req;
  logic        busy;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [11:0] mem_din;

  int unsigned n_tests;
  int unsigned n_fail;

  logic        exp_we[9];
  logic [16:0] exp_addr[9];

  canvas_writer #(
    .WIDTH   (320),
    .HEIGHT  (240),
    .BRUSH   (3),
    .BG_COLOR(12'hFFF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pen_valid(pen_valid),
    .pen_ready(pen_ready),
    .pen_x    (pen_x),
    .pen_y    (pen_y),
    .pen_color(pen_color),
    .clear_req(clear_req),
    .busy     (busy),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Presents one pen sample, then checks the nine stamp cycles against exp_we/exp_addr.
  // clear_req is raised during stamp position clr_at (-1 for none).
  task automatic run_stamp(input logic [8:0] x, input logic [7:0] y,
                           input logic [11:0] c, input int clr_at);
    @(negedge clk);
    pen_valid = 1'b1;
    pen_x     = x;
    pen_y     = y;
    pen_color = c;
    @(negedge clk);
    pen_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check("stamp_busy", busy, 1);
      check("stamp_rdy", pen_ready, 0);
      check("stamp_we", mem_we, exp_we[i]);
      check("stamp_addr", mem_addr, exp_addr[i]);
      if (exp_we[i]) check("stamp_din", mem_din, c);
      clear_req = (i == clr_at);
      @(negedge clk);
    end
    clear_req = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_we"}, mem_we, 0);
    check({tag, "_rdy"}, pen_ready, 1);
  endtask

  initial begin
    int unsigned sweep_err;
    n_tests   = 0;
    n_fail    = 0;
    pen_valid = 1'b0;
    pen_x     = '0;
    pen_y     = '0;
    pen_color = '0;
    clear_req = 1'b0;
    rst       = 1'b1;
    #2 rst    = 1'b0;

    // Reset held with toggling inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_we", mem_we, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_rdy", pen_ready, 0);
      check("rst_busy", busy, 0);
      pen_valid = ~pen_valid;
      clear_req = ~clear_req;
      pen_x     = 9'(37 * i);
    end
    pen_valid = 1'b0;
    clear_req = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    check("rel_rdy", pen_ready, 1);
    check("rel_busy", busy, 0);
    check("rel_we", mem_we, 0);

    // Interior stamp at (100,50)
    exp_we   = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    exp_addr = '{15779, 15780, 15781, 16099, 16100, 16101, 16419, 16420, 16421};
    run_stamp(9'd100, 8'd50, 12'hF00, -1);
    check_idle("post_stamp");

    // Top-left corner: addr holds the previous value while clipped
    exp_we   = '{0, 0, 0, 0, 1, 1, 0, 1, 1};
    exp_addr = '{16421, 16421, 16421, 16421, 0, 1, 1, 320, 321};
    run_stamp(9'd0, 8'd0, 12'h0A5, -1);
    check_idle("post_corner");
    check("corner_din_hold", mem_din, 12'h0A5);

    // Fully off-canvas sample still takes nine cycles
    exp_we   = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_addr = '{321, 321, 321, 321, 321, 321, 321, 321, 321};
    run_stamp(9'd400, 8'd10, 12'h123, -1);
    check_idle("post_offcanvas");

    // Clear from IDLE with a pen sample held; second clear_req mid-sweep is ignored
    @(negedge clk);
    clear_req = 1'b1;
    pen_valid = 1'b1;
    pen_x     = 9'd5;
    pen_y     = 8'd5;
    pen_color = 12'h00F;
    @(negedge clk);
    clear_req = 1'b0;
    sweep_err = 0;
    for (int i = 0; i < 76800; i++) begin
      if (mem_we !== 1'b1 || mem_addr !== 17'(i) || mem_din !== 12'hFFF ||
          busy !== 1'b1 || pen_ready !== 1'b0) sweep_err++;
      clear_req = (i == 500);
      @(negedge clk);
    end
    clear_req = 1'b0;
    check("clear_sweep_errs", sweep_err, 0);
    check("clear_end_busy", busy, 0);
    check("clear_end_we", mem_we, 0);
    check("clear_end_rdy", pen_ready, 1);
    @(negedge clk);
    check("held_pen_busy", busy, 1);
    check("held_pen_we", mem_we, 1);
    check("held_pen_addr", mem_addr, 1284);
    check("held_pen_din", mem_din, 12'h00F);
    pen_valid = 1'b0;
    for (int i = 0; i < 9; i++) @(negedge clk);
    check_idle("post_held_pen");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_second_sweep_we", mem_we, 0);
      check("no_second_sweep_busy", busy, 0);
    end

    // clear_req on stamp cycle 4 queues a clear straight after the stamp
    exp_we   = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    exp_addr = '{2889, 2890, 2891, 3209, 3210, 3211, 3529, 3530, 3531};
    run_stamp(9'd10, 8'd10, 12'h0F0, 3);
    check("queued_clr_we", mem_we, 1);
    check("queued_clr_addr", mem_addr, 0);
    check("queued_clr_din", mem_din, 12'hFFF);
    check("queued_clr_busy", busy, 1);
    check("queued_clr_rdy", pen_ready, 0);
    sweep_err = 0;
    for (int i = 1; i <= 1000; i++) begin
      @(negedge clk);
      if (mem_we !== 1'b1 || mem_addr !== 17'(i)) sweep_err++;
    end
    check("queued_clr_sweep_errs", sweep_err, 0);
    check("queued_clr_at_1000", mem_addr, 1000);

    // Asynchronous reset in the middle of the clear
    rst = 1'b0;
    #1;
    check("async_rst_we", mem_we, 0);
    check("async_rst_addr", mem_addr, 0);
    check("async_rst_din", mem_din, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_rdy", pen_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_idle("after_rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
